// File: rtl/pair_packer.sv
// Packs pairs of WIDTH-bit upstream beats into one 2*WIDTH-bit downstream word.
// A flush emits a held lone beat as a zero-padded partial word.
module pair_packer #(
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     us_data,
  input  logic                 us_valid,
  output logic                 us_ready,
  input  logic                 flush,
  output logic [2*WIDTH-1:0]   ds_data,
  output logic                 ds_valid,
  output logic                 ds_half,
  input  logic                 ds_ready,
  output logic [15:0]          pair_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_lo;
  logic [2*WIDTH-1:0]   r_ds_data;
  logic                 r_ds_valid;
  logic                 r_ds_half;
  logic [15:0]          r_pair_count;

  logic                 w_slot_free;
  logic                 w_us_ready;
  logic                 w_capture;
  logic                 w_load_full;
  logic                 w_load_half;
  logic                 w_ds_xfer;

  function automatic logic [2*WIDTH-1:0] pack_word(input logic [WIDTH-1:0] hi,
                                                   input logic [WIDTH-1:0] lo);
    return {hi, lo};
  endfunction

  // The output slot can take a new word if empty or emptying this cycle.
  assign w_slot_free = !r_ds_valid || ds_ready;
  assign w_ds_xfer   = r_ds_valid && ds_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_us_ready  = 1'b1;
    w_capture   = 1'b0;
    w_load_full = 1'b0;
    w_load_half = 1'b0;
    case (r_state)
      EMPTY: begin
        w_us_ready = 1'b1;
        if (us_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = HALF;
        end
      end
      HALF: begin
        w_us_ready = w_slot_free;
        // A second beat takes priority; a simultaneous flush adds nothing.
        if (us_valid && w_slot_free) begin
          w_load_full = 1'b1;
          w_state_nxt = EMPTY;
        end else if (flush && w_slot_free) begin
          w_load_half = 1'b1;
          w_state_nxt = EMPTY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lo <= '0;
    end else if (w_capture) begin
      r_lo <= us_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ds_data  <= '0;
      r_ds_half  <= 1'b0;
      r_ds_valid <= 1'b0;
    end else if (w_load_full) begin
      r_ds_data  <= pack_word(us_data, r_lo);
      r_ds_half  <= 1'b0;
      r_ds_valid <= 1'b1;
    end else if (w_load_half) begin
      r_ds_data  <= pack_word('0, r_lo);
      r_ds_half  <= 1'b1;
      r_ds_valid <= 1'b1;
    end else if (w_ds_xfer) begin
      r_ds_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pair_count <= '0;
    end else if (w_ds_xfer) begin
      r_pair_count <= r_pair_count + 16'd1;
    end
  end

  assign us_ready   = w_us_ready;
  assign ds_data    = r_ds_data;
  assign ds_valid   = r_ds_valid;
  assign ds_half    = r_ds_half;
  assign pair_count = r_pair_count;

endmodule

// File: tb/tb_pair_packer.sv
// Scoreboard bench for pair_packer: directed scenarios push expected words,
// a negedge monitor pops and compares each downstream hand-off.
module tb_pair_packer;

  logic        clock;
  logic        reset;
  logic [15:0] us_data;
  logic        us_valid;
  logic        us_ready;
  logic        flush;
  logic [31:0] ds_data;
  logic        ds_valid;
  logic        ds_half;
  logic        ds_ready;
  logic [15:0] pair_count;

  int          n_checks;
  int          n_errors;
  logic [32:0] exp_q[$];
  logic [15:0] exp_cnt;
  logic        prev_stall;
  logic [32:0] prev_word;

  pair_packer #(.WIDTH(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .us_data    (us_data),
    .us_valid   (us_valid),
    .us_ready   (us_ready),
    .flush      (flush),
    .ds_data    (ds_data),
    .ds_valid   (ds_valid),
    .ds_half    (ds_half),
    .ds_ready   (ds_ready),
    .pair_count (pair_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic push(input logic half, input logic [31:0] word);
    exp_q.push_back({half, word});
  endtask

  // Monitor: compares every downstream transfer and checks stall stability.
  initial begin
    prev_stall = 1'b0;
    prev_word  = '0;
    exp_cnt    = '0;
  end

  always @(negedge clock) begin
    logic [32:0] e;
    if (!reset) begin
      prev_stall = 1'b0;
      exp_cnt    = '0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, ds_valid}, 32'd1);
        check("stall_data", ds_data, prev_word[31:0]);
        check("stall_half", {31'd0, ds_half}, {31'd0, prev_word[32]});
      end
      if (ds_valid && ds_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got 0x%0h half=%0d, expected no word", ds_data, ds_half);
        end else begin
          e = exp_q.pop_front();
          check("word_data", ds_data, e[31:0]);
          check("word_half", {31'd0, ds_half}, {31'd0, e[32]});
        end
        check("count_at_xfer", {16'd0, pair_count}, {16'd0, exp_cnt});
        exp_cnt = exp_cnt + 16'd1;
      end
      prev_stall = ds_valid && !ds_ready;
      prev_word  = {ds_half, ds_data};
    end
  end

  initial begin
    logic [15:0] lo;
    logic        have_lo;
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    us_data  = '0;
    us_valid = 1'b0;
    flush    = 1'b0;
    ds_ready = 1'b0;
    step();
    step();
    check("rst_valid", {31'd0, ds_valid}, 32'd0);
    check("rst_half", {31'd0, ds_half}, 32'd0);
    check("rst_data", ds_data, 32'd0);
    check("rst_count", {16'd0, pair_count}, 32'd0);
    check("rst_us_ready", {31'd0, us_ready}, 32'd1);
    reset = 1'b1;

    // Back-to-back pair with downstream ready
    ds_ready = 1'b1;
    step();
    us_valid = 1'b1; us_data = 16'h1111;
    step();
    us_data = 16'h2222;
    push(1'b0, 32'h2222_1111);
    #1 check("s1_us_ready_half", {31'd0, us_ready}, 32'd1);
    step();
    us_valid = 1'b0;
    check("s1_latency_valid", {31'd0, ds_valid}, 32'd1);
    check("s1_data", ds_data, 32'h2222_1111);
    step();
    check("s1_count", {16'd0, pair_count}, 32'd1);
    check("s1_drained", {31'd0, ds_valid}, 32'd0);

    // Lone beat flushed as partial word
    us_valid = 1'b1; us_data = 16'hABCD;
    step();
    us_valid = 1'b0; flush = 1'b1;
    push(1'b1, 32'h0000_ABCD);
    step();
    flush = 1'b1;
    check("s2_partial_valid", {31'd0, ds_valid}, 32'd1);
    check("s2_partial_half", {31'd0, ds_half}, 32'd1);
    check("s2_partial_data", ds_data, 32'h0000_ABCD);
    step();
    check("s2_one_cycle", {31'd0, ds_valid}, 32'd0);
    step();
    flush = 1'b0;
    check("s2_empty_flush_ignored", {31'd0, ds_valid}, 32'd0);

    // Backpressure: one word pending, third beat accepted, fourth stalled
    ds_ready = 1'b0;
    us_valid = 1'b1; us_data = 16'h1111;
    step();
    us_data = 16'h2222;
    push(1'b0, 32'h2222_1111);
    step();
    us_data = 16'h3333;
    #1 check("s3_accept_3333", {31'd0, us_ready}, 32'd1);
    step();
    us_data = 16'h4444;
    push(1'b0, 32'h4444_3333);
    #1 check("s3_stall_4444", {31'd0, us_ready}, 32'd0);
    step();
    check("s3_stall_still", {31'd0, us_ready}, 32'd0);
    check("s3_data_held", ds_data, 32'h2222_1111);
    ds_ready = 1'b1;
    #1 check("s3_ready_through", {31'd0, us_ready}, 32'd1);
    step();
    us_valid = 1'b0;
    check("s3_next_word", ds_data, 32'h4444_3333);
    step();
    check("s3_count", {16'd0, pair_count}, 32'd4);

    // Flush coincident with second beat yields a single full word
    us_valid = 1'b1; us_data = 16'h6666;
    step();
    us_data = 16'h5555; flush = 1'b1;
    push(1'b0, 32'h5555_6666);
    step();
    us_valid = 1'b0; flush = 1'b0;
    check("s4_full_half", {31'd0, ds_half}, 32'd0);
    step();
    step();
    check("s4_no_partial", {31'd0, ds_valid}, 32'd0);

    // Reset with a pending word and a held half discards both
    ds_ready = 1'b0;
    us_valid = 1'b1; us_data = 16'hAAAA;
    step();
    us_data = 16'hBBBB;
    step();
    us_data = 16'h7777;
    step();
    us_valid = 1'b0;
    reset = 1'b0;
    step();
    check("s5_rst_valid", {31'd0, ds_valid}, 32'd0);
    check("s5_rst_count", {16'd0, pair_count}, 32'd0);
    check("s5_rst_data", ds_data, 32'd0);
    reset = 1'b1;
    ds_ready = 1'b1; flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    check("s5_no_stale_word", {31'd0, ds_valid}, 32'd0);
    check("s5_count_zero", {16'd0, pair_count}, 32'd0);
    us_valid = 1'b1; us_data = 16'h8888;
    step();
    us_data = 16'h9999;
    push(1'b0, 32'h9999_8888);
    step();
    us_valid = 1'b0;
    step();
    step();

    // Preload near wrap, then a random scramble with a pairing model
    force dut.r_pair_count = 16'hFFFE;
    exp_cnt = 16'hFFFE;
    step();
    release dut.r_pair_count;
    check("wrap_preload", {16'd0, pair_count}, 32'h0000_FFFE);
    have_lo = 1'b0;
    lo = '0;
    for (int i = 0; i < 200; i++) begin
      us_valid = ($urandom_range(0, 3) != 0);
      us_data  = 16'($urandom);
      ds_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (us_valid && us_ready) begin
        if (have_lo) begin
          push(1'b0, {us_data, lo});
          have_lo = 1'b0;
        end else begin
          lo = us_data;
          have_lo = 1'b1;
        end
      end
      step();
    end
    us_valid = 1'b0;
    ds_ready = 1'b1;
    if (have_lo) begin
      push(1'b1, {16'h0000, lo});
      flush = 1'b1;
    end
    step();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("rand_queue_empty", exp_q.size(), 32'd0);
    check("rand_count_final", {16'd0, pair_count}, {16'd0, exp_cnt});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
